// File: rtl/trace_sink_buffer.sv
// rtl/trace_sink_buffer.sv - kept-instruction FIFO with packetised valid/ready output and loss statistics
package continuous_monitoring_system_pkg;
  localparam int RISC_V_INSTRUCTION_WIDTH = 32;
endpackage

module trace_sink_buffer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int INSTR_WIDTH = RISC_V_INSTRUCTION_WIDTH,
  parameter int DEPTH       = 16,
  parameter int PACKET_LEN  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  input  logic [INSTR_WIDTH-1:0]   instr,
  input  logic                     drop_instr,
  input  logic                     flush,
  input  logic                     clear_counters,
  output logic                     m_valid,
  output logic [INSTR_WIDTH-1:0]   m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_WIDTH-1:0]     dropped_count,
  output logic [CNT_WIDTH-1:0]     overflow_count,
  output logic                     overflow_flag,
  output logic                     flush_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_LVL  = (AW+1)'(1);
  localparam logic [PW-1:0] LAST_CNT = PW'(PACKET_LEN - 1);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_e;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;
  logic [PW-1:0]          pkt_cnt_q;
  state_e                 state_q, state_d;
  logic                   flush_done_q, flush_done_d;
  logic [CNT_WIDTH-1:0]   dropped_q, overflow_q;
  logic                   flag_q;

  logic kept, dropped, wr_en, rd_en, lost;

  // Classify the sampled instruction and decide write/read/loss for this cycle
  always_comb begin
    kept    = instr_valid & ~drop_instr;
    dropped = instr_valid & drop_instr;
    // Fullness uses the pre-edge occupancy; a same-cycle read does not make room
    wr_en   = kept && (state_q == ST_RUN) && (count_q != FULL_LVL);
    rd_en   = m_valid && m_ready;
    lost    = kept && !wr_en;
  end

  // Output stream: head of FIFO, masked to zero while empty so reset shows m_data=0
  always_comb begin
    m_valid = (count_q != '0);
    m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
    m_last  = m_valid && ((pkt_cnt_q == LAST_CNT) ||
                          ((state_q == ST_FLUSH) && (count_q == ONE_LVL)));
  end

  assign fill_level     = count_q;
  assign dropped_count  = dropped_q;
  assign overflow_count = overflow_q;
  assign overflow_flag  = flag_q;
  assign flush_done     = flush_done_q;

  // FIFO storage; contents need no reset because m_data is masked by m_valid
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= instr;
  end

  // FIFO pointers, occupancy and packet word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        pkt_cnt_q <= m_last ? '0 : pkt_cnt_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Flush sequencing: enter FLUSH unless already empty, leave on the final word's handshake
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          if (count_q == '0) flush_done_d = 1'b1;
          else               state_d      = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (rd_en && m_last && (count_q == ONE_LVL)) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state and registered flush_done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Saturating drop/loss statistics; clear takes priority over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_q  <= '0;
      overflow_q <= '0;
      flag_q     <= 1'b0;
    end else if (clear_counters) begin
      dropped_q  <= '0;
      overflow_q <= '0;
      flag_q     <= 1'b0;
    end else begin
      if (dropped && (dropped_q != '1)) dropped_q <= dropped_q + 1'b1;
      if (lost) begin
        flag_q <= 1'b1;
        if (overflow_q != '1) overflow_q <= overflow_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/trace_sink_buffer.md
Name: trace_sink_buffer

Overview:
- Consumer end of the trace_filter interface.
- Samples each traced instruction together with trace_filter's same-cycle drop_instr verdict.
- Buffers the kept instructions in a FIFO and streams them to the host/DMA over a valid/ready stream, framed into fixed-length packets with a last flag.
- Keeps drop and overflow statistics, and supports an explicit flush that closes a partial packet.

Parameters:
- INSTR_WIDTH, default RISC_V_INSTRUCTION_WIDTH (32): width of the instruction word, taken from continuous_monitoring_system_pkg.
- DEPTH, default 16: number of FIFO entries; must be a power of two, minimum 2.
- PACKET_LEN, default 8: words per packet; m_last is asserted on the PACKET_LEN-th word.
- CNT_WIDTH, default 16: width of the statistics counters.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instr carries a traced instruction this cycle.
- instr  in  INSTR_WIDTH  instruction word, the same value driven into trace_filter.
- drop_instr  in  1  trace_filter verdict for instr, valid in the same cycle.
- flush  in  1  single-cycle request to drain the FIFO and terminate the current packet.
- clear_counters  in  1  synchronous clear of the statistics counters and the sticky flag.
- m_valid  out  1  output word available.
- m_data  out  INSTR_WIDTH  output word.
- m_last  out  1  this word ends a packet.
- m_ready  in  1  sink accepts the word; a handshake occurs when m_valid and m_ready are both high.
- fill_level  out  log2(DEPTH)+1  current FIFO occupancy.
- dropped_count  out  CNT_WIDTH  number of instructions dropped by the filter.
- overflow_count  out  CNT_WIDTH  number of kept instructions lost because of full or flush.
- overflow_flag  out  1  sticky; set on the first loss.
- flush_done  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset (asynchronous, rst_n low): FIFO empty; state RUN; packet word counter = 0.
- Outputs at reset: m_valid=0, m_data=0, m_last=0, fill_level=0, both counters=0, overflow_flag=0, flush_done=0.
- Kept item: instr_valid=1 and drop_instr=0.
- Dropped item: instr_valid=1 and drop_instr=1.
  - dropped_count increments (saturating) in every state.
  - A dropped item is never written to the FIFO.
- Write rule: in RUN, a kept item is written when fill_level < DEPTH.
  - Fullness is judged on the pre-edge occupancy. A same-cycle read handshake does not free space for that cycle's write.
- Loss rule: a kept item that is not written increments overflow_count (saturating at all-ones) and sets overflow_flag.
  - This applies to a kept item while full in RUN, and to any kept item in FLUSH.
- Latency: a word written at edge N makes m_valid high after edge N. There is no combinational bypass from instr to m_data.
- Output stream:
  - m_data is the FIFO head.
  - m_valid = (fill_level != 0).
  - m_data and m_valid hold stable while m_valid=1 and m_ready=0.
  - A read and a write in the same cycle leave fill_level unchanged.
- Pointers wrap modulo DEPTH. fill_level counts from 0 to DEPTH inclusive.
- Packet counter: increments on each handshake and resets to 0 on the handshake of a word with m_last=1.
- m_last = m_valid and (counter == PACKET_LEN-1, or (state == FLUSH and fill_level == 1)).
- FSM, states RUN and FLUSH:
  - RUN -> FLUSH when flush=1. If the FIFO is empty at that point, go instead straight to RUN and pulse flush_done in the next cycle.
  - FLUSH -> RUN on the handshake of the word with m_last=1 while fill_level==1; flush_done pulses in the cycle after that handshake.
  - flush while already in FLUSH is ignored.
- clear_counters: zeroes dropped_count, overflow_count and overflow_flag at the next edge.
  - Clear wins over a same-cycle increment.
  - It does not affect the FIFO or the FSM.
- Reset asserted mid-packet or mid-flush discards all FIFO contents immediately; the bench checks the values listed under Reset.
- Target implementation size: roughly 150–250 lines of RTL.

Test Plan:
- Kept stream: 20 kept items 0x00000013+i with m_ready=1 -> 20 words out in order, each one cycle after input; m_last on words 8 and 16; dropped_count=0.
- Dropped items: 10 items with drop_instr set on indices 2 and 7 -> 8 words out, dropped_count=2, no gaps or reordering.
- Overflow: m_ready=0, 20 kept items -> fill_level=16, overflow_count=4, overflow_flag=1; then m_ready=1 -> exactly the first 16 words come out; clear_counters -> counters and flag read 0.
- Flush: 3 kept items, then a flush pulse -> third word has m_last=1, flush_done pulses once, packet counter restarts so the next 8 words end with m_last on word 8.
  - 1 kept item arriving during FLUSH -> overflow_count increments by 1.
- Empty flush: flush with an empty FIFO -> flush_done pulses one cycle later; m_valid stays 0.
- Full with simultaneous read: fill_level=16, m_ready=1, and a kept item in the same cycle -> item lost (overflow_count+1), fill_level=15.
  - Reset mid-stream -> m_valid=0 and fill_level=0 asynchronously.
